// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Each digit owns a slot of SCAN_DIV mclk cycles. The slot is split into an
// all-off BLANK lead-in, a DRIVE window whose length follows the brightness
// level, and an OFF tail. The display controls are captured once per frame,
// so a frame never shows a mix of old and new values.
//
// Ports
//   mclk        system clock
//   rst_n       asynchronous active-low reset
//   disp_val    16-bit value, digit i = disp_val[4i+3:4i], digit 0 rightmost
//   disp_dp     decimal point per digit, 1 = lit
//   disp_en     per-digit enable, 0 = digit dark
//   lz_supp     leading-zero suppression enable
//   brightness  duty level 0..7 (7 = full)
//   ax_segout   {dp,g,f,e,d,c,b,a}, active-low
//   ax_digout   digit select, active-low, at most one bit low
//   frame_tick  one-cycle pulse on the cycle after each frame snapshot
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 128,
  parameter int BLANK_CYC = 8
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [15:0] disp_val,
  input  logic [3:0]  disp_dp,
  input  logic [3:0]  disp_en,
  input  logic        lz_supp,
  input  logic [2:0]  brightness,
  output logic [7:0]  ax_segout,
  output logic [3:0]  ax_digout,
  output logic        frame_tick
);

  localparam int PRE_W    = $clog2(SCAN_DIV);
  // DRIVE window grows by this many cycles per brightness step
  localparam int DRV_STEP = (SCAN_DIV - BLANK_CYC) / 8;

  typedef enum logic [1:0] {
    SLOT_BLANK,
    SLOT_DRIVE,
    SLOT_OFF
  } slot_t;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hexseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0] pre_p0, pre_nxt;
  logic [1:0]       dig_p0, dig_nxt;
  logic             snap;

  logic [15:0] val_sh;
  logic [3:0]  dp_sh;
  logic [3:0]  en_sh;
  logic        lz_sh;
  logic [2:0]  bri_sh;

  slot_t       slot;
  logic [3:0]  nib;
  logic        upper_zero;
  logic [7:0]  seg_d;
  logic [3:0]  sel_d;

  assign snap = (pre_p0 == '0) && (dig_p0 == 2'd0);

  // ---- stage p0: scan position register ----
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_p0 <= '0;
      dig_p0 <= 2'd0;
    end else begin
      pre_p0 <= pre_nxt;
      dig_p0 <= dig_nxt;
    end
  end

  always_comb begin
    pre_nxt = pre_p0 + PRE_W'(1);
    dig_nxt = dig_p0;
    if (pre_p0 == PRE_W'(SCAN_DIV - 1)) begin
      pre_nxt = '0;
      dig_nxt = dig_p0 + 2'd1;
    end
  end

  // Frame snapshot: taken on the first slot cycle of digit 0, which is also
  // the first edge after reset release.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      val_sh <= '0;
      dp_sh  <= '0;
      en_sh  <= '0;
      lz_sh  <= 1'b0;
      bri_sh <= '0;
    end else if (snap) begin
      val_sh <= disp_val;
      dp_sh  <= disp_dp;
      en_sh  <= disp_en;
      lz_sh  <= lz_supp;
      bri_sh <= brightness;
    end
  end

  // Slot phase decoded from the prescaler position.
  always_comb begin
    int pre_i;
    int drv_end;
    pre_i   = int'(pre_p0);
    drv_end = BLANK_CYC + DRV_STEP * (int'(bri_sh) + 1);
    if (pre_i < BLANK_CYC)    slot = SLOT_BLANK;
    else if (pre_i < drv_end) slot = SLOT_DRIVE;
    else                      slot = SLOT_OFF;
  end

  // Digit pattern for the current slot. A digit is zero-suppressed when it
  // and every nibble above it are zero; digit 0 never qualifies.
  always_comb begin
    nib = val_sh[{dig_p0, 2'b00} +: 4];
    case (dig_p0)
      2'd1:    upper_zero = (val_sh[15:4] == '0);
      2'd2:    upper_zero = (val_sh[15:8] == '0);
      2'd3:    upper_zero = (val_sh[15:12] == '0);
      default: upper_zero = 1'b0;
    endcase
    seg_d = 8'hFF;
    sel_d = 4'hF;
    if (slot == SLOT_DRIVE && en_sh[dig_p0]) begin
      if (!(lz_sh && upper_zero)) begin
        sel_d = ~(4'b0001 << dig_p0);
        seg_d = ~{dp_sh[dig_p0], hexseg(nib)};
      end else if (dp_sh[dig_p0]) begin
        // suppressed digit still shows its decimal point
        sel_d = ~(4'b0001 << dig_p0);
        seg_d = 8'h7F;
      end
    end
  end

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      ax_segout  <= 8'hFF;
      ax_digout  <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      ax_segout  <= seg_d;
      ax_digout  <= sel_d;
      frame_tick <= snap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with default parameters (128-cycle slot,
// 8-cycle blanking). Outputs are sampled on the falling edge of mclk.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  logic        mclk;
  logic        rst_n;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;
  logic [3:0]  disp_en;
  logic        lz_supp;
  logic [2:0]  brightness;
  logic [7:0]  ax_segout;
  logic [3:0]  ax_digout;
  logic        frame_tick;

  int checks;
  int errors;
  int tick_cnt;

  seg7_scan_ctrl #(.SCAN_DIV(128), .BLANK_CYC(8)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .disp_val   (disp_val),
    .disp_dp    (disp_dp),
    .disp_en    (disp_en),
    .lz_supp    (lz_supp),
    .brightness (brightness),
    .ax_segout  (ax_segout),
    .ax_digout  (ax_digout),
    .frame_tick (frame_tick)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock, then sample at the following falling edge.
  task automatic step();
    @(posedge mclk);
    @(negedge mclk);
    if (frame_tick === 1'b1) tick_cnt++;
  endtask

  // Sample j (1..128) of the window reflects slot position pre=j.
  task automatic run_slot(input string tag, input int d, input logic [7:0] eseg, input int eon);
    int on_cnt, match_cnt, first_on, last_on, bad;
    logic [3:0] esel;
    esel = ~(4'b0001 << d);
    on_cnt = 0; match_cnt = 0; first_on = -1; last_on = -1; bad = 0;
    for (int j = 1; j <= 128; j++) begin
      step();
      if (ax_digout !== 4'hF) begin
        on_cnt++;
        if (first_on < 0) first_on = j;
        last_on = j;
        if (ax_digout === esel && ax_segout === eseg) match_cnt++;
      end else if (ax_segout !== 8'hFF) begin
        bad++;
      end
      if ($countones(~ax_digout) > 1) bad++;
    end
    chk({tag, "_on"}, on_cnt, eon);
    chk({tag, "_match"}, match_cnt, eon);
    chk({tag, "_bad"}, bad, 0);
    if (eon > 0) begin
      chk({tag, "_first"}, first_on, 8);
      chk({tag, "_last"}, last_on, 8 + eon - 1);
    end
  endtask

  // Must be called right after the sample that saw frame_tick.
  task automatic run_frame(input string tag,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input int o0, input int o1, input int o2, input int o3);
    tick_cnt = 0;
    run_slot({tag, "_d0"}, 0, s0, o0);
    run_slot({tag, "_d1"}, 1, s1, o1);
    run_slot({tag, "_d2"}, 2, s2, o2);
    run_slot({tag, "_d3"}, 3, s3, o3);
    chk({tag, "_ticks"}, tick_cnt, 1);
    chk({tag, "_tick_end"}, frame_tick, 1'b1);
  endtask

  // Lets the frame already latched play out so new inputs take effect.
  task automatic skip_frame(input string tag);
    for (int j = 0; j < 512; j++) step();
    chk({tag, "_skip_tick"}, frame_tick, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; tick_cnt = 0;
    rst_n = 1'b0;
    disp_val = 16'h1234; disp_dp = 4'h0; disp_en = 4'hF;
    lz_supp = 1'b0; brightness = 3'd7;

    // Reset held: pins idle
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_seg", ax_segout, 8'hFF);
      chk("rst_dig", ax_digout, 4'hF);
      chk("rst_tick", frame_tick, 1'b0);
    end
    rst_n = 1'b1;
    step();
    chk("first_tick", frame_tick, 1'b1);
    chk("first_seg", ax_segout, 8'hFF);
    chk("first_dig", ax_digout, 4'hF);

    // Plain 1234 at full brightness
    run_frame("f1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 120, 120, 120, 120);

    // Leading-zero suppression
    lz_supp = 1'b1; disp_val = 16'h0050;
    skip_frame("lz50");
    run_frame("lz50", 8'hC0, 8'h92, 8'hFF, 8'hFF, 120, 120, 0, 0);
    disp_val = 16'h0000;
    skip_frame("lz00");
    run_frame("lz00", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 120, 0, 0, 0);
    disp_dp = 4'b0100;
    skip_frame("lzdp");
    run_frame("lzdp", 8'hC0, 8'hFF, 8'h7F, 8'hFF, 120, 0, 120, 0);

    // Disabled digit stays dark despite dp; dp on a lit digit
    lz_supp = 1'b0; disp_val = 16'h1234; disp_en = 4'b1011; disp_dp = 4'b0101;
    skip_frame("endp");
    run_frame("endp", 8'h19, 8'hB0, 8'hFF, 8'hF9, 120, 120, 0, 120);

    // Brightness duty
    disp_en = 4'hF; disp_dp = 4'h0; brightness = 3'd0;
    skip_frame("bri0");
    run_frame("bri0", 8'h99, 8'hB0, 8'hA4, 8'hF9, 15, 15, 15, 15);
    brightness = 3'd3;
    skip_frame("bri3");
    run_frame("bri3", 8'h99, 8'hB0, 8'hA4, 8'hF9, 60, 60, 60, 60);

    // Mid-frame value change is held off until the next snapshot
    brightness = 3'd7;
    skip_frame("snap");
    tick_cnt = 0;
    run_slot("snap_d0", 0, 8'h99, 120);
    disp_val = 16'hABCD;
    run_slot("snap_d1", 1, 8'hB0, 120);
    run_slot("snap_d2", 2, 8'hA4, 120);
    run_slot("snap_d3", 3, 8'hF9, 120);
    chk("snap_ticks", tick_cnt, 1);
    run_frame("fABCD", 8'hA1, 8'hC6, 8'h83, 8'h88, 120, 120, 120, 120);

    // Asynchronous reset inside a DRIVE window
    for (int j = 0; j < 20; j++) step();
    chk("pre_rst_dig", ax_digout, 4'hE);
    chk("pre_rst_seg", ax_segout, 8'hA1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", ax_segout, 8'hFF);
    chk("async_dig", ax_digout, 4'hF);
    disp_val = 16'h00F0; lz_supp = 1'b1;
    for (int j = 0; j < 3; j++) step();
    chk("async_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    step();
    chk("restart_tick", frame_tick, 1'b1);
    run_frame("restart", 8'hC0, 8'h8E, 8'hFF, 8'hFF, 120, 120, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
